riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
Parametrised multi-cycle load/store unit placed between the core datapath and the data-memory/IO bridge. It replaces the single-cycle, always-ready data access with a valid/ready request and one-cycle response pulse on the core side, and a req/ack handshake on the memory side. It handles byte-lane steering, byte enables, load sign/zero extension, misalignment detection and a bus timeout.

Parameters:
XLEN, 32, data width; legal values 32 or 64; NB = XLEN/8 byte lanes
ADDR_W, 32, byte-address width
TIMEOUT_CYCLES, 255, maximum cycles in WAIT without mem_ack before abort; must be ≥1
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  core access request
req_ready  out  1  high only in IDLE
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 dword (XLEN=64 only)
req_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  extended load data; 0 for stores and errors
resp_err  out  2  00 ok, 01 misaligned/illegal size, 10 timeout
mem_req  out  1  memory request, held until ack or timeout
mem_we  out  1  write strobe
mem_be  out  NB  byte enables
mem_addr  out  ADDR_W  NB-aligned address (low log2(NB) bits zero)
mem_wdata  out  XLEN  lane-replicated store data
mem_ack  in  1  memory done; mem_rdata valid in same cycle
mem_rdata  in  XLEN  full-width read word

Behaviour:
- Reset (rst=0, async): state=IDLE, req_ready=1, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=00, timeout counter=0. mem_req deasserts immediately, without waiting for a clock edge.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid is high at a clock edge, register we/size/unsigned/addr/wdata.
  - Misaligned (half with addr[0]≠0; word with addr[1:0]≠0; dword with addr[2:0]≠0) or size=11 with XLEN=32: go to RESP with err=01. No mem_req is ever issued.
  - Otherwise go to WAIT.
- WAIT: mem_req=1. mem_we/mem_be/mem_addr/mem_wdata are registered and stable for the whole WAIT.
  - Counter increments each WAIT cycle.
  - If mem_ack is high: capture the extended load data and go to RESP with err=00.
  - Else, if the counter reaches TIMEOUT_CYCLES: go to RESP with err=10 and rdata=0.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_err hold their values until the next RESP.
- Latency: accept at cycle 0; mem_req in cycle 1; ack in cycle 1 gives resp_valid in cycle 2. Misaligned access gives resp_valid in cycle 1.
- mem_ack in IDLE or RESP is ignored.
- Lane math: off = addr[log2(NB)-1:0].
  - Byte: be = 1<<off; wdata = byte replicated NB times.
  - Half: be = 3<<off; half replicated.
  - Word: be = 0xF<<off; word replicated.
  - Dword: all ones.
- Load extension: select mem_rdata[8·off +: size_bytes·8].
  - Signed loads extend from the MSB of the selected field (e.g. byte off=2 uses bit 23). The top-level LB bug, which took bit 15 regardless of offset, is not reproduced.
  - Unsigned loads zero-extend.
- Arithmetic: all address/lane computations are modulo 2^ADDR_W; the counter saturates and is cleared on entry to WAIT.

Decomposition:
- riscv_defs.v gains: LSU_SIZE_B/H/W/D, LSU_ERR_OK/MISALIGN/TIMEOUT, LSU_ST_IDLE/WAIT/RESP encodings.
- One combinational sub-module, riscv_lsu_align. It holds store lane replication, byte-enable generation, the misalign check and load extract/extend. It is parametrised by XLEN and unit-testable alone.
- riscv_lsu holds the FSM, request registers and timeout counter.

Test Plan:
1. Reset: hold rst=0 during a WAIT → mem_req falls within the same cycle; after release req_ready=1, resp_valid=0, resp_err=00.
2. SB addr=0x1003, wdata=0x000000A5, ack in first WAIT cycle → mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_we=1; resp_valid two cycles after accept, err=00, rdata=0.
3. With mem_rdata=0x12803456 at addr=0x2002:
   - LB → 0xFFFFFF80
   - LBU → 0x00000080
   - LH → 0x00001280
   - LW at 0x2000 → 0x12803456
4. LW addr=0x3002 → mem_req never rises; resp_valid in cycle 1, err=01, rdata=0. Also with XLEN=32, size=11 → err=01.
5. TIMEOUT_CYCLES=4, no ack → mem_req high exactly 4 cycles, then resp err=10. Repeat with ack on the 4th cycle → err=00 with data.
6. Back-to-back: req_valid held high with two loads, ack delayed 3 cycles each → second accept only on the cycle after the first resp_valid; resp_valid is never high two consecutive cycles.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, response error codes
// and FSM state values (kept as plain constants for legacy riscv_defs parity).
package riscv_lsu_pkg;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;
    localparam logic [1:0] LSU_SIZE_D = 2'b11;

    localparam logic [1:0] LSU_ERR_OK       = 2'b00;
    localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
    localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'b10;

    localparam logic [1:0] LSU_ST_IDLE = 2'd0;
    localparam logic [1:0] LSU_ST_WAIT = 2'd1;
    localparam logic [1:0] LSU_ST_RESP = 2'd2;

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side valid/ready request/response bundle and memory-side req/ack bundle.
// In both interfaces the master modport is the side that issues requests.
interface riscv_lsu_core_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic [1:0]        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface riscv_lsu_mem_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [XLEN/8-1:0] be;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic              ack;
    logic [XLEN-1:0]   rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  ack, rdata
    );
    modport slave (
        input  req, we, be, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: store replication, byte enables, misalign check,
// and load field extraction with sign/zero extension.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [1:0]      st_size,
    input  logic [OFFW-1:0] st_off,
    input  logic [XLEN-1:0] st_wdata,
    output logic [NB-1:0]   st_be,
    output logic [XLEN-1:0] st_wdata_rep,
    output logic            st_misalign,
    input  logic [1:0]      ld_size,
    input  logic [OFFW-1:0] ld_off,
    input  logic            ld_unsigned,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] ld_shifted;
    logic [XLEN-1:0] ld_mask;
    logic            ld_sign;

    always_comb begin
        st_be        = '0;
        st_wdata_rep = st_wdata;
        st_misalign  = 1'b0;
        case (st_size)
            LSU_SIZE_B: begin
                st_be        = NB'(1) << st_off;
                st_wdata_rep = {NB{st_wdata[7:0]}};
            end
            LSU_SIZE_H: begin
                st_be        = NB'(3) << st_off;
                st_wdata_rep = {(NB/2){st_wdata[15:0]}};
                st_misalign  = st_off[0];
            end
            LSU_SIZE_W: begin
                st_be        = NB'(15) << st_off;
                st_wdata_rep = {(NB/4){st_wdata[31:0]}};
                st_misalign  = (st_off[1:0] != 2'b00);
            end
            default: begin
                st_be        = '1;
                st_wdata_rep = st_wdata;
                st_misalign  = (XLEN != 64) || (st_off != '0);
            end
        endcase
    end

    // Sign bit is taken from the top of the selected field, not a fixed lane.
    always_comb begin
        ld_shifted = ld_rdata >> {ld_off, 3'b000};
        ld_mask    = '1;
        ld_sign    = 1'b0;
        case (ld_size)
            LSU_SIZE_B: begin
                ld_mask = XLEN'(8'hFF);
                ld_sign = ld_shifted[7];
            end
            LSU_SIZE_H: begin
                ld_mask = XLEN'(16'hFFFF);
                ld_sign = ld_shifted[15];
            end
            LSU_SIZE_W: begin
                ld_mask = XLEN'(32'hFFFF_FFFF);
                ld_sign = ld_shifted[31];
            end
            default: begin
                ld_mask = '1;
                ld_sign = 1'b0;
            end
        endcase
        ld_data = ld_shifted & ld_mask;
        if (!ld_unsigned && ld_sign) begin
            ld_data = ld_data | ~ld_mask;
        end
    end

endmodule

// File: rtl/riscv_lsu.sv
// Multi-cycle load/store unit: valid/ready core port, req/ack memory port,
// with misalign rejection and a bounded wait for mem_ack.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    riscv_lsu_core_if.slave core,
    riscv_lsu_mem_if.master mem
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic [NB-1:0]     be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;

    logic [NB-1:0]     st_be;
    logic [XLEN-1:0]   st_wdata;
    logic              st_misalign;
    logic [XLEN-1:0]   ld_data;

    riscv_lsu_align #(.XLEN(XLEN)) u_align (
        .st_size      (core.req_size),
        .st_off       (core.req_addr[OFFW-1:0]),
        .st_wdata     (core.req_wdata),
        .st_be        (st_be),
        .st_wdata_rep (st_wdata),
        .st_misalign  (st_misalign),
        .ld_size      (size_q),
        .ld_off       (off_q),
        .ld_unsigned  (uns_q),
        .ld_rdata     (mem.rdata),
        .ld_data      (ld_data)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            LSU_ST_IDLE: begin
                if (core.req_valid) begin
                    we_d    = core.req_we;
                    size_d  = core.req_size;
                    uns_d   = core.req_unsigned;
                    off_d   = core.req_addr[OFFW-1:0];
                    be_d    = st_be;
                    addr_d  = {core.req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                    wdata_d = st_wdata;
                    cnt_d   = '0;
                    if (st_misalign) begin
                        state_d = LSU_ST_RESP;
                        rdata_d = '0;
                        err_d   = LSU_ERR_MISALIGN;
                    end else begin
                        state_d = LSU_ST_WAIT;
                    end
                end
            end
            LSU_ST_WAIT: begin
                if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (mem.ack) begin
                    state_d = LSU_ST_RESP;
                    rdata_d = we_q ? '0 : ld_data;
                    err_d   = LSU_ERR_OK;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = LSU_ST_RESP;
                    rdata_d = '0;
                    err_d   = LSU_ERR_TIMEOUT;
                end
            end
            LSU_ST_RESP: state_d = LSU_ST_IDLE;
            default:     state_d = LSU_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LSU_ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= LSU_SIZE_B;
            uns_q   <= 1'b0;
            off_q   <= '0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= LSU_ERR_OK;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // mem_req decodes straight from state so reset drops it asynchronously.
    assign core.req_ready  = (state_q == LSU_ST_IDLE);
    assign core.resp_valid = (state_q == LSU_ST_RESP);
    assign core.resp_rdata = rdata_q;
    assign core.resp_err   = err_q;
    assign mem.req         = (state_q == LSU_ST_WAIT);
    assign mem.we          = we_q;
    assign mem.be          = be_q;
    assign mem.addr        = addr_q;
    assign mem.wdata       = wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu (XLEN=32, TIMEOUT_CYCLES=4): reset, store lanes,
// load extension, misalign, timeout and back-to-back handshake.
module tb_riscv_lsu;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    riscv_lsu_core_if #(.XLEN(32), .ADDR_W(32)) core_if ();
    riscv_lsu_mem_if  #(.XLEN(32), .ADDR_W(32)) mem_if ();

    riscv_lsu #(
        .XLEN           (32),
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .core (core_if),
        .mem  (mem_if)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        core_if.req_valid    = 1'b1;
        core_if.req_we       = we;
        core_if.req_size     = size;
        core_if.req_unsigned = uns;
        core_if.req_addr     = addr;
        core_if.req_wdata    = wdata;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        tick();
        core_if.req_valid = 1'b0;
        n_cmp++; if (mem_if.req !== 1'b1) begin n_bad++; $display("FAIL rst_pre_req got %b exp 1", mem_if.req); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (mem_if.req !== 1'b0) begin n_bad++; $display("FAIL rst_async_req got %b exp 0", mem_if.req); end
        @(negedge clk);
        rst = 1'b1;
        n_cmp++; if (core_if.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b exp 1", core_if.req_ready); end
        n_cmp++; if (core_if.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid got %b exp 0", core_if.resp_valid); end
        n_cmp++; if (core_if.resp_err !== 2'b00) begin n_bad++; $display("FAIL rst_err got %b exp 00", core_if.resp_err); end
        n_cmp++; if (mem_if.be !== 4'b0000) begin n_bad++; $display("FAIL rst_be got %b exp 0000", mem_if.be); end
        n_cmp++; if (mem_if.addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h exp 0", mem_if.addr); end
    endtask

    task automatic test_store_byte();
        issue(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5);
        tick();
        core_if.req_valid = 1'b0;
        n_cmp++; if (mem_if.req !== 1'b1) begin n_bad++; $display("FAIL sb_req got %b exp 1", mem_if.req); end
        n_cmp++; if (mem_if.addr !== 32'h0000_1000) begin n_bad++; $display("FAIL sb_addr got %h exp 00001000", mem_if.addr); end
        n_cmp++; if (mem_if.be !== 4'b1000) begin n_bad++; $display("FAIL sb_be got %b exp 1000", mem_if.be); end
        n_cmp++; if (mem_if.wdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL sb_wdata got %h exp a5a5a5a5", mem_if.wdata); end
        n_cmp++; if (mem_if.we !== 1'b1) begin n_bad++; $display("FAIL sb_we got %b exp 1", mem_if.we); end
        n_cmp++; if (core_if.resp_valid !== 1'b0) begin n_bad++; $display("FAIL sb_early_resp got %b exp 0", core_if.resp_valid); end
        mem_if.ack   = 1'b1;
        mem_if.rdata = 32'hDEAD_BEEF;
        tick();
        mem_if.ack   = 1'b0;
        mem_if.rdata = 32'h0;
        n_cmp++; if (core_if.resp_valid !== 1'b1) begin n_bad++; $display("FAIL sb_resp_valid got %b exp 1", core_if.resp_valid); end
        n_cmp++; if (core_if.resp_err !== 2'b00) begin n_bad++; $display("FAIL sb_err got %b exp 00", core_if.resp_err); end
        n_cmp++; if (core_if.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL sb_rdata got %h exp 0", core_if.resp_rdata); end
        n_cmp++; if (mem_if.req !== 1'b0) begin n_bad++; $display("FAIL sb_req_drop got %b exp 0", mem_if.req); end
        tick();
        n_cmp++; if (core_if.resp_valid !== 1'b0) begin n_bad++; $display("FAIL sb_resp_pulse got %b exp 0", core_if.resp_valid); end
        n_cmp++; if (core_if.req_ready !== 1'b1) begin n_bad++; $display("FAIL sb_ready got %b exp 1", core_if.req_ready); end
    endtask

    task automatic run_load(input string nm, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [3:0] exp_be, input logic [31:0] exp_data);
        issue(1'b0, size, uns, addr, 32'h0);
        tick();
        core_if.req_valid = 1'b0;
        n_cmp++; if (mem_if.be !== exp_be) begin n_bad++; $display("FAIL %s_be got %b exp %b", nm, mem_if.be, exp_be); end
        n_cmp++; if (mem_if.addr !== {addr[31:2], 2'b00}) begin n_bad++; $display("FAIL %s_addr got %h exp %h", nm, mem_if.addr, {addr[31:2], 2'b00}); end
        n_cmp++; if (mem_if.we !== 1'b0) begin n_bad++; $display("FAIL %s_we got %b exp 0", nm, mem_if.we); end
        mem_if.ack   = 1'b1;
        mem_if.rdata = rdata;
        tick();
        mem_if.ack   = 1'b0;
        mem_if.rdata = 32'h0;
        n_cmp++; if (core_if.resp_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid got %b exp 1", nm, core_if.resp_valid); end
        n_cmp++; if (core_if.resp_rdata !== exp_data) begin n_bad++; $display("FAIL %s_rdata got %h exp %h", nm, core_if.resp_rdata, exp_data); end
        n_cmp++; if (core_if.resp_err !== 2'b00) begin n_bad++; $display("FAIL %s_err got %b exp 00", nm, core_if.resp_err); end
        tick();
    endtask

    task automatic test_load_extend();
        run_load("lb",   2'b00, 1'b0, 32'h0000_2002, 32'h1280_3456, 4'b0100, 32'hFFFF_FF80);
        run_load("lbu",  2'b00, 1'b1, 32'h0000_2002, 32'h1280_3456, 4'b0100, 32'h0000_0080);
        run_load("lh",   2'b01, 1'b0, 32'h0000_2002, 32'h1280_3456, 4'b1100, 32'h0000_1280);
        run_load("lw",   2'b10, 1'b0, 32'h0000_2000, 32'h1280_3456, 4'b1111, 32'h1280_3456);
        run_load("lh0",  2'b01, 1'b0, 32'h0000_2000, 32'h0000_8001, 4'b0011, 32'hFFFF_8001);
        run_load("lhu0", 2'b01, 1'b1, 32'h0000_2000, 32'h0000_8001, 4'b0011, 32'h0000_8001);
        n_cmp++; if (core_if.resp_rdata !== 32'h0000_8001) begin n_bad++; $display("FAIL ld_hold got %h exp 00008001", core_if.resp_rdata); end
    endtask

    task automatic test_misaligned();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0);
        tick();
        core_if.req_valid = 1'b0;
        n_cmp++; if (mem_if.req !== 1'b0) begin n_bad++; $display("FAIL mis_req got %b exp 0", mem_if.req); end
        n_cmp++; if (core_if.resp_valid !== 1'b1) begin n_bad++; $display("FAIL mis_valid got %b exp 1", core_if.resp_valid); end
        n_cmp++; if (core_if.resp_err !== 2'b01) begin n_bad++; $display("FAIL mis_err got %b exp 01", core_if.resp_err); end
        n_cmp++; if (core_if.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL mis_rdata got %h exp 0", core_if.resp_rdata); end
        mem_if.ack = 1'b1;
        tick();
        mem_if.ack = 1'b0;
        n_cmp++; if (mem_if.req !== 1'b0) begin n_bad++; $display("FAIL mis_req2 got %b exp 0", mem_if.req); end
        n_cmp++; if (core_if.resp_valid !== 1'b0) begin n_bad++; $display("FAIL mis_pulse got %b exp 0", core_if.resp_valid); end
        n_cmp++; if (core_if.resp_err !== 2'b01) begin n_bad++; $display("FAIL mis_err_hold got %b exp 01", core_if.resp_err); end
        issue(1'b0, 2'b01, 1'b0, 32'h0000_3001, 32'h0);
        tick();
        core_if.req_valid = 1'b0;
        n_cmp++; if (core_if.resp_err !== 2'b01) begin n_bad++; $display("FAIL mis_half_err got %b exp 01", core_if.resp_err); end
        tick();
        issue(1'b1, 2'b11, 1'b0, 32'h0000_4000, 32'h1234_5678);
        tick();
        core_if.req_valid = 1'b0;
        n_cmp++; if (mem_if.req !== 1'b0) begin n_bad++; $display("FAIL dw_req got %b exp 0", mem_if.req); end
        n_cmp++; if (core_if.resp_valid !== 1'b1) begin n_bad++; $display("FAIL dw_valid got %b exp 1", core_if.resp_valid); end
        n_cmp++; if (core_if.resp_err !== 2'b01) begin n_bad++; $display("FAIL dw_err got %b exp 01", core_if.resp_err); end
        tick();
    endtask

    task automatic test_timeout();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
        tick();
        core_if.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem_if.req !== 1'b1) begin n_bad++; $display("FAIL to_req%0d got %b exp 1", i, mem_if.req); end
            tick();
        end
        n_cmp++; if (mem_if.req !== 1'b0) begin n_bad++; $display("FAIL to_req_end got %b exp 0", mem_if.req); end
        n_cmp++; if (core_if.resp_valid !== 1'b1) begin n_bad++; $display("FAIL to_valid got %b exp 1", core_if.resp_valid); end
        n_cmp++; if (core_if.resp_err !== 2'b10) begin n_bad++; $display("FAIL to_err got %b exp 10", core_if.resp_err); end
        n_cmp++; if (core_if.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL to_rdata got %h exp 0", core_if.resp_rdata); end
        tick();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0);
        tick();
        core_if.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem_if.req !== 1'b1) begin n_bad++; $display("FAIL ta_req%0d got %b exp 1", i, mem_if.req); end
            if (i == 3) begin
                mem_if.ack   = 1'b1;
                mem_if.rdata = 32'hCAFE_F00D;
            end
            tick();
        end
        mem_if.ack   = 1'b0;
        mem_if.rdata = 32'h0;
        n_cmp++; if (core_if.resp_valid !== 1'b1) begin n_bad++; $display("FAIL ta_valid got %b exp 1", core_if.resp_valid); end
        n_cmp++; if (core_if.resp_err !== 2'b00) begin n_bad++; $display("FAIL ta_err got %b exp 00", core_if.resp_err); end
        n_cmp++; if (core_if.resp_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL ta_rdata got %h exp cafef00d", core_if.resp_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_ready, exp_valid, exp_req;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0);
        for (int c = 0; c < 11; c++) begin
            exp_ready = (c == 0) || (c == 5) || (c == 10);
            exp_valid = (c == 4) || (c == 9);
            exp_req   = (c >= 1 && c <= 3) || (c >= 6 && c <= 8);
            n_cmp++; if (core_if.req_ready !== exp_ready) begin n_bad++; $display("FAIL b2b_ready c%0d got %b exp %b", c, core_if.req_ready, exp_ready); end
            n_cmp++; if (core_if.resp_valid !== exp_valid) begin n_bad++; $display("FAIL b2b_valid c%0d got %b exp %b", c, core_if.resp_valid, exp_valid); end
            n_cmp++; if (mem_if.req !== exp_req) begin n_bad++; $display("FAIL b2b_req c%0d got %b exp %b", c, mem_if.req, exp_req); end
            if (c == 4) begin
                n_cmp++; if (core_if.resp_rdata !== 32'h1122_3344) begin n_bad++; $display("FAIL b2b_rdata1 got %h exp 11223344", core_if.resp_rdata); end
            end
            if (c == 9) begin
                n_cmp++; if (core_if.resp_rdata !== 32'h0000_00CC) begin n_bad++; $display("FAIL b2b_rdata2 got %h exp 000000cc", core_if.resp_rdata); end
            end
            if (c == 6) begin
                n_cmp++; if (mem_if.addr !== 32'h0000_6004) begin n_bad++; $display("FAIL b2b_addr2 got %h exp 00006004", mem_if.addr); end
                core_if.req_valid = 1'b0;
            end
            if (c == 5) issue(1'b0, 2'b00, 1'b1, 32'h0000_6005, 32'h0);
            mem_if.ack   = (c == 3) || (c == 8);
            mem_if.rdata = (c == 3) ? 32'h1122_3344 : ((c == 8) ? 32'hAABB_CCDD : 32'h0);
            tick();
        end
        core_if.req_valid = 1'b0;
        mem_if.ack        = 1'b0;
    endtask

    initial begin
        core_if.req_valid    = 1'b0;
        core_if.req_we       = 1'b0;
        core_if.req_size     = 2'b00;
        core_if.req_unsigned = 1'b0;
        core_if.req_addr     = 32'h0;
        core_if.req_wdata    = 32'h0;
        mem_if.ack           = 1'b0;
        mem_if.rdata         = 32'h0;
        test_reset();
        test_store_byte();
        test_load_extend();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
